// File: rtl/scmp_muldiv_seq.sv
// SC/MP MPY/DIV sequencer: drives the shared ALU with ADD/RRL over 8 bit-iterations.
// Define SCMP_MULDIV_DIV_EN to build the divide path; otherwise DIV completes at once with overflow.
`ifndef SCMP_ALU_ADD
`define SCMP_ALU_ADD 4'h4
`endif
`ifndef SCMP_ALU_RRL
`define SCMP_ALU_RRL 4'hA
`endif

module scmp_muldiv_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op_div,
  input  logic [7:0] hi_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] b_i,
  output logic       alu_own,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  input  logic [7:0] alu_res,
  input  logic       alu_cy_o,
  output logic       busy,
  output logic       done,
  output logic [7:0] hi_o,
  output logic [7:0] lo_o,
  output logic       ov_o
);

  localparam logic [3:0] OP_ADD = `SCMP_ALU_ADD;
  localparam logic [3:0] OP_RRL = `SCMP_ALU_RRL;

`ifdef SCMP_MULDIV_DIV_EN
  typedef enum logic [2:0] {IDLE, CHK, MADD, MSHR, DSHL, DSUB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MADD, MSHR, DONE} state_t;
`endif

  state_t     r_state;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] r_m;
  logic       r_cy;
  logic [2:0] r_n;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_hi_o;
  logic [7:0] r_lo_o;
  logic       r_ov;

`ifdef SCMP_MULDIV_DIV_EN
  // Trial subtract succeeds if the bit shifted out of hi was set or hi >= m.
  logic w_take;
  assign w_take = r_cy | alu_cy_o;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign hi_o = r_hi_o;
  assign lo_o = r_lo_o;
  assign ov_o = r_ov;

  always_comb begin
    alu_own = 1'b0;
    alu_op  = OP_ADD;
    alu_a   = '0;
    alu_b   = '0;
    alu_cy  = 1'b0;
    case (r_state)
      MADD: begin
        alu_own = 1'b1;
        alu_a   = r_hi;
        alu_b   = r_lo[0] ? r_m : '0;
      end
      MSHR: begin
        alu_own = 1'b1;
        alu_op  = OP_RRL;
        alu_a   = r_hi;
        alu_cy  = r_cy;
      end
`ifdef SCMP_MULDIV_DIV_EN
      CHK, DSUB: begin
        alu_own = 1'b1;
        alu_a   = r_hi;
        alu_b   = ~r_m;
        alu_cy  = 1'b1;
      end
      DSHL: begin
        alu_own = 1'b1;
        alu_a   = r_hi;
        alu_b   = r_hi;
        alu_cy  = r_lo[7];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_cy    <= 1'b0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi_o  <= '0;
      r_lo_o  <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_lo   <= lo_i;
            r_m    <= b_i;
            r_n    <= '0;
            r_busy <= 1'b1;
            if (op_div) begin
              r_hi <= hi_i;
`ifdef SCMP_MULDIV_DIV_EN
              r_ov    <= 1'b0;
              r_state <= CHK;
`else
              r_ov    <= 1'b1;
              r_hi_o  <= hi_i;
              r_lo_o  <= lo_i;
              r_done  <= 1'b1;
              r_state <= DONE;
`endif
            end else begin
              r_hi    <= '0;
              r_ov    <= 1'b0;
              r_state <= MADD;
            end
          end
        end
        MADD: begin
          r_hi    <= alu_res;
          r_cy    <= alu_cy_o;
          r_state <= MSHR;
        end
        MSHR: begin
          r_hi <= alu_res;
          r_lo <= {alu_cy_o, r_lo[7:1]};
          r_n  <= r_n + 3'd1;
          if (r_n == 3'd7) begin
            r_hi_o  <= alu_res;
            r_lo_o  <= {alu_cy_o, r_lo[7:1]};
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= MADD;
          end
        end
`ifdef SCMP_MULDIV_DIV_EN
        CHK: begin
          if (alu_cy_o) begin
            r_ov    <= 1'b1;
            r_hi_o  <= r_hi;
            r_lo_o  <= r_lo;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= DSHL;
          end
        end
        DSHL: begin
          r_hi    <= alu_res;
          r_cy    <= alu_cy_o;
          r_lo    <= {r_lo[6:0], 1'b0};
          r_state <= DSUB;
        end
        DSUB: begin
          if (w_take) begin
            r_hi    <= alu_res;
            r_lo[0] <= 1'b1;
          end
          r_n <= r_n + 3'd1;
          if (r_n == 3'd7) begin
            r_hi_o  <= w_take ? alu_res : r_hi;
            r_lo_o  <= {r_lo[7:1], w_take | r_lo[0]};
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= DSHL;
          end
        end
`endif
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
